ahb_apb_bridge: RTL and testbench

//  AHB-Lite subordinate to APB4 bridge: converts single AHB transfers into APB4 SETUP/ACCESS transfers.

---
 rtl/ahb_apb_bridge_pkg.sv | 31 +++
 rtl/ahb_apb_bridge_if.sv | 47 ++++
 rtl/apb_timeout.sv | 43 ++++
 rtl/ahb_apb_bridge.sv | 116 +++++++++++
 tb/tb_ahb_apb_bridge.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB4 bridge: transfer types, FSM states, PPROT layout.
package ahb_apb_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    // AHB HPROT[0] is "data", so the APB instruction bit is its inverse.
    function automatic logic [2:0] map_pprot(input logic [3:0] hprot);
        logic [2:0] p;
        p               = '0;
        p[PPROT_PRIV]   = hprot[1];
        p[PPROT_NONSEC] = 1'b0;
        p[PPROT_INSTR]  = ~hprot[0];
        return p;
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// AHB-Lite subordinate side and APB4 requester side of the bridge in one bundle.
interface ahb_apb_bridge_if #(
    parameter int PA_BITS = 56,
    parameter int XLEN    = 64,
    parameter int NSLV    = 4
);
    logic                   HSEL;
    logic [PA_BITS-1:0]     HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [2:0]             HSIZE;
    logic [3:0]             HPROT;
    logic [XLEN-1:0]        HWDATA;
    logic [XLEN/8-1:0]      HWSTRB;
    logic                   HREADY;
    logic                   HREADYOUT;
    logic                   HRESP;
    logic [XLEN-1:0]        HRDATA;

    logic [NSLV-1:0]        PSEL;
    logic                   PENABLE;
    logic [PA_BITS-1:0]     PADDR;
    logic                   PWRITE;
    logic [XLEN-1:0]        PWDATA;
    logic [XLEN/8-1:0]      PSTRB;
    logic [2:0]             PPROT;
    logic [NSLV-1:0]        PREADY;
    logic [NSLV*XLEN-1:0]   PRDATA;
    logic [NSLV-1:0]        PSLVERR;

    // Bridge view.
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HWSTRB, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    // Surrounding system view (AHB manager plus APB peripherals).
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HWSTRB, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );

endinterface

// File: rtl/apb_timeout.sv
// Counts stalled APB ACCESS cycles and flags the cycle in which the limit is reached.
module apb_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] count_q, count_d;

            always_comb begin
                count_d = count_q;
                if (clr_i) begin
                    count_d = '0;
                end else if (en_i) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            // Fires on the TIMEOUT-th stalled cycle, so ACCESS lasts exactly TIMEOUT cycles.
            assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timer
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr_i, en_i};
            assign expired_o     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite subordinate that turns single transfers into APB4 SETUP/ACCESS cycles across NSLV peripherals.
module ahb_apb_bridge
    import ahb_apb_bridge_pkg::*;
#(
    parameter int PA_BITS       = 56,
    parameter int XLEN          = 64,
    parameter int NSLV          = 4,
    parameter int SLV_SIZE_BITS = 12,
    parameter int TIMEOUT       = 256
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_apb_bridge_if.slave  bus
);

    localparam int IDX_W    = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int MAX_SIZE = $clog2(XLEN / 8);

    bridge_state_e        state_q, state_d, start_st;
    logic [PA_BITS-1:0]   paddr_q;
    logic                 pwrite_q;
    logic [2:0]           pprot_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     req_idx;

    logic accept, req_legal, can_accept, take;
    logic sel_ready, sel_err, complete, apb_active;
    logic timer_clr, timer_en, expired;
    logic unused_bits;

    assign unused_bits = ^{bus.HTRANS[0], bus.HPROT[3:2]};

    assign req_idx   = (NSLV > 1) ? bus.HADDR[SLV_SIZE_BITS +: IDX_W] : '0;
    assign accept    = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
    assign req_legal = ({1'b0, req_idx} < (IDX_W + 1)'(NSLV)) && (bus.HSIZE <= 3'(MAX_SIZE));
    assign start_st  = req_legal ? ST_SETUP : ST_ERR1;

    assign sel_ready = bus.PREADY[idx_q];
    assign sel_err   = bus.PSLVERR[idx_q];
    assign complete  = (state_q == ST_ACCESS) && sel_ready && !sel_err;

    // A new address phase is only taken when the previous data phase is ending.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2) || complete;
    assign take       = accept && can_accept;

    always_comb begin
        state_d       = state_q;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                bus.HRESP = (state_q == ST_ERR2);
                state_d   = take ? start_st : ST_IDLE;
            end
            ST_SETUP: begin
                bus.HREADYOUT = 1'b0;
                state_d       = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.HREADYOUT = complete;
                if (complete) begin
                    state_d = take ? start_st : ST_IDLE;
                end else if (sel_ready || expired) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                state_d       = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pprot_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                paddr_q  <= bus.HADDR;
                pwrite_q <= bus.HWRITE;
                pprot_q  <= map_pprot(bus.HPROT);
                idx_q    <= req_idx;
            end
        end
    end

    assign timer_clr = (state_d == ST_SETUP);
    assign timer_en  = (state_q == ST_ACCESS) && !sel_ready;

    apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (expired)
    );

    // Write data is taken straight from HWDATA, which the manager holds while we stall.
    assign apb_active  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.PSEL    = apb_active ? (NSLV'(1) << idx_q) : '0;
    assign bus.PENABLE = (state_q == ST_ACCESS);
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PPROT   = pprot_q;
    assign bus.PWDATA  = apb_active ? bus.HWDATA : '0;
    assign bus.PSTRB   = (apb_active && pwrite_q) ? bus.HWSTRB : '0;
    assign bus.HRDATA  = complete ? bus.PRDATA[idx_q * XLEN +: XLEN] : '0;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomised AHB transfers through the bridge against a cycle-count/response model of the protocol.
module tb_ahb_apb_bridge;
    import ahb_apb_bridge_pkg::*;

    localparam int NS  = 3;
    localparam int TMO = 8;
    localparam int PA  = 56;
    localparam int XL  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_apb_bridge_if #(.PA_BITS(PA), .XLEN(XL), .NSLV(NS)) bus ();

    ahb_apb_bridge #(
        .PA_BITS(PA), .XLEN(XL), .NSLV(NS), .SLV_SIZE_BITS(12), .TIMEOUT(TMO)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int          slot;
        logic [PA-1:0] haddr;
        logic        wr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [2:0]  size;
        logic [3:0]  prot;
        int          waits;
        logic        err;
        logic [63:0] rdata;
    } txn_t;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cfg_waits = 0;
    logic        cfg_err = 1'b0;
    int          acc_cnt;
    logic [63:0] prdata_mem [NS];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Peripheral model: the selected slave answers after cfg_waits stalled ACCESS cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (bus.PENABLE && !(|bus.PREADY)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bus.PREADY[i]  = bus.PENABLE && bus.PSEL[i] && (acc_cnt >= cfg_waits);
            bus.PSLVERR[i] = bus.PENABLE && bus.PSEL[i] && (acc_cnt >= cfg_waits) && cfg_err;
        end
    end

    assign bus.PRDATA = {prdata_mem[2], prdata_mem[1], prdata_mem[0]};
    assign bus.HREADY = bus.HREADYOUT;

    function automatic txn_t make_txn(input int slot, input logic wr, input int waits, input logic err);
        txn_t t;
        t.slot          = slot;
        t.haddr         = PA'({$urandom, $urandom});
        t.haddr[13:12]  = 2'(slot);
        t.wr            = wr;
        t.wdata         = {$urandom, $urandom};
        t.strb          = 8'($urandom);
        t.size          = 3'($urandom_range(0, 3));
        t.prot          = 4'($urandom);
        t.waits         = waits;
        t.err           = err;
        t.rdata         = {$urandom, $urandom};
        return t;
    endfunction

    task automatic addr_phase(input txn_t t);
        bus.HSEL   = 1'b1;
        bus.HTRANS = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        bus.HADDR  = t.haddr;
        bus.HWRITE = t.wr;
        bus.HSIZE  = t.size;
        bus.HPROT  = t.prot;
    endtask

    // Runs the data phase of t (its address was taken at the preceding edge); optionally presents nxt.
    task automatic data_phase(input txn_t t, input bit has_next, input txn_t nxt, input int id);
        int            cyc, exp_cyc;
        bit            done, pen_seen, changed, legal, exp_err;
        logic          resp, prev_resp, s_wr;
        logic [63:0]   rdata, s_wdata;
        logic [NS-1:0] psel_seen;
        logic [PA-1:0] s_addr;
        logic [7:0]    s_strb;
        logic [2:0]    s_prot;

        legal = (t.slot < NS) && (t.size <= 3);
        if (!legal) begin
            exp_cyc = 2;            exp_err = 1'b1;
        end else if (t.waits >= TMO) begin
            exp_cyc = TMO + 3;      exp_err = 1'b1;
        end else begin
            exp_cyc = t.waits + 2 + (t.err ? 2 : 0);
            exp_err = t.err;
        end

        cyc = 0; done = 0; pen_seen = 0; changed = 0;
        resp = 0; prev_resp = 0; rdata = '0; psel_seen = '0;
        s_wr = 0; s_wdata = '0; s_addr = '0; s_strb = '0; s_prot = '0;

        while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.HWDATA = t.wdata;
                bus.HWSTRB = t.strb;
                cfg_waits  = t.waits;
                cfg_err    = t.err;
                for (int i = 0; i < NS; i++) prdata_mem[i] = {$urandom, $urandom};
                if (t.slot < NS) prdata_mem[t.slot] = t.rdata;
                if (has_next) addr_phase(nxt);
                else begin
                    bus.HSEL   = 1'($urandom);
                    bus.HTRANS = 2'($urandom_range(0, 1));
                end
            end
            #1;
            cyc++;
            psel_seen |= bus.PSEL;
            if (bus.PENABLE) begin
                if (pen_seen && (s_addr !== bus.PADDR || s_wdata !== bus.PWDATA || s_strb !== bus.PSTRB))
                    changed = 1;
                pen_seen = 1;
                s_addr = bus.PADDR; s_wdata = bus.PWDATA; s_strb = bus.PSTRB;
                s_wr = bus.PWRITE; s_prot = bus.PPROT;
            end
            if (bus.HREADYOUT) begin
                done  = 1;
                resp  = bus.HRESP;
                rdata = bus.HRDATA;
            end else begin
                prev_resp = bus.HRESP;
            end
        end

        check_val("done", 64'(done), 64'd1);
        check_val("cycles", 64'(cyc), 64'(exp_cyc));
        check_val("hresp", 64'(resp), 64'(exp_err));
        check_val("psel", 64'(psel_seen), legal ? 64'(1 << t.slot) : 64'd0);
        if (exp_err) begin
            check_val("hresp_first", 64'(prev_resp), 64'd1);
            check_val("hrdata_err", rdata, 64'd0);
        end
        if (legal) begin
            check_val("paddr", 64'(s_addr), 64'(t.haddr));
            check_val("pwrite", 64'(s_wr), 64'(t.wr));
            check_val("pprot", 64'(s_prot), 64'({~t.prot[0], 1'b0, t.prot[1]}));
            check_val("pstrb", 64'(s_strb), t.wr ? 64'(t.strb) : 64'd0);
            check_val("apb_stable", 64'(changed), 64'd0);
            if (t.wr) check_val("pwdata", s_wdata, t.wdata);
            else if (!exp_err) check_val("hrdata", rdata, t.rdata);
        end else begin
            check_val("no_penable", 64'(pen_seen), 64'd0);
        end
        $display("txn %0d: slot=%0d wr=%0d size=%0d waits=%0d slverr=%0d pipe=%0d -> cycles=%0d hresp=%0d",
                 id, t.slot, t.wr, t.size, t.waits, t.err, has_next, cyc, resp);
    endtask

    txn_t q[$];
    bit   pipe_q[$];

    initial begin
        txn_t t;
        int   r;

        bus.HSEL = 0; bus.HTRANS = HTRANS_IDLE; bus.HADDR = '0; bus.HWRITE = 0;
        bus.HSIZE = 0; bus.HPROT = 0; bus.HWDATA = '0; bus.HWSTRB = '0;
        for (int i = 0; i < NS; i++) prdata_mem[i] = '0;

        #3;
        check_val("rst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
        check_val("rst_hresp", 64'(bus.HRESP), 64'd0);
        check_val("rst_hrdata", bus.HRDATA, 64'd0);
        check_val("rst_psel", 64'(bus.PSEL), 64'd0);
        check_val("rst_penable", 64'(bus.PENABLE), 64'd0);
        check_val("rst_paddr", 64'(bus.PADDR), 64'd0);
        check_val("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        check_val("rst_pprot", 64'(bus.PPROT), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // BUSY with HSEL high must not start a transfer.
        @(negedge clk);
        bus.HSEL = 1; bus.HTRANS = HTRANS_BUSY;
        @(negedge clk); #1;
        check_val("busy_ready", 64'(bus.HREADYOUT), 64'd1);
        check_val("busy_hresp", 64'(bus.HRESP), 64'd0);
        check_val("busy_psel", 64'(bus.PSEL), 64'd0);
        bus.HSEL = 0; bus.HTRANS = HTRANS_IDLE;

        t = make_txn(1, 0, 0, 0); t.haddr = 56'h1008; t.rdata = 64'hDEAD; t.size = 3;
        q.push_back(t); pipe_q.push_back(0);
        t = make_txn(0, 1, 3, 0); t.wdata = 64'h1234; t.strb = 8'h0F;
        q.push_back(t); pipe_q.push_back(0);
        q.push_back(make_txn(2, 0, 0, 1)); pipe_q.push_back(0);
        q.push_back(make_txn(3, 0, 0, 0)); pipe_q.push_back(0);
        q.push_back(make_txn(1, 0, 20, 0)); pipe_q.push_back(0);
        q.push_back(make_txn(0, 1, 1, 0)); pipe_q.push_back(1);
        q.push_back(make_txn(2, 0, 0, 0)); pipe_q.push_back(0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            t = make_txn($urandom_range(0, 3), 1'($urandom),
                         (r < 7) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, 7) : $urandom_range(9, 12),
                         ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 9) == 0) t.size = 3'($urandom_range(4, 7));
            q.push_back(t);
            pipe_q.push_back((n != 39) && ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < q.size(); i++) begin
            if (i == 0 || !pipe_q[i-1]) begin
                @(negedge clk);
                addr_phase(q[i]);
            end
            data_phase(q[i], pipe_q[i], pipe_q[i] ? q[i+1] : q[i], i);
        end

        // Reset in the middle of a stalled ACCESS.
        t = make_txn(1, 1, 6, 0);
        @(negedge clk); addr_phase(t);
        @(negedge clk); bus.HSEL = 0; bus.HTRANS = HTRANS_IDLE; cfg_waits = 6; cfg_err = 0;
        @(negedge clk); @(negedge clk); #1;
        check_val("pre_rst_penable", 64'(bus.PENABLE), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_psel", 64'(bus.PSEL), 64'd0);
        check_val("midrst_penable", 64'(bus.PENABLE), 64'd0);
        check_val("midrst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        t = make_txn(0, 0, 2, 0);
        @(negedge clk); addr_phase(t);
        data_phase(t, 0, t, 99);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
